// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and next-PC op codes for the fetch/step core
// Contents:
//   state_e  : fetch FSM state, also exported on o_dbg_state_data
//   PC_INC4  : next PC = PC + 4
//   PC_REL   : next PC = PC + imm
//   PC_ABS   : next PC = imm
//   PC_HOLD  : next PC = PC (refetch the same instruction)
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    localparam logic [1:0] PC_INC4 = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_ABS  = 2'b10;
    localparam logic [1:0] PC_HOLD = 2'b11;

endpackage

// File: rtl/core_if.sv
// rtl/core_if.sv - AXI4-Lite read channel bundle used for instruction fetch
// Parameters: ADDR_W (araddr width), DATA_W (rdata width).
// Signals: arvalid/arready/araddr (read address), rvalid/rready/rdata/rresp (read data).
// Modports:
//   master : fetch side (drives arvalid, araddr, rready)
//   slave  : memory side (drives arready, rvalid, rdata, rresp)
// The core only ever reads instruction memory, so the write channels are not
// carried in this bundle.
interface if_axi4_lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid,
        output araddr,
        output rready,
        input  arready,
        input  rvalid,
        input  rdata,
        input  rresp
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  rready,
        output arready,
        output rvalid,
        output rdata,
        output rresp
    );

endinterface

// File: rtl/core_pc_gen.sv
// rtl/core_pc_gen.sv - program counter register with next-PC mux and adder
// Ports:
//   clk, rstn : clock, asynchronous active-low reset (PC returns to RESET_PC)
//   i_load    : commit a new PC this cycle
//   i_op      : next-PC select (PC_INC4 / PC_REL / PC_ABS / PC_HOLD)
//   i_imm     : offset or absolute target
//   o_pc      : current PC (registered)
module pc_gen
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_load,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] next_pc;

    always_comb begin
        next_pc = pc_q;
        case (i_op)
            PC_INC4: next_pc = pc_q + XLEN'(4);
            PC_REL:  next_pc = pc_q + i_imm;
            PC_ABS:  next_pc = i_imm;
            default: next_pc = pc_q;
        endcase

        // Adders wrap naturally at XLEN; every committed PC is word aligned.
        pc_d = pc_q;
        if (i_load) begin
            pc_d = {next_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/core.sv
// rtl/core.sv - single-outstanding instruction fetch loop with external step control
// Parameters: XLEN, IMADDRLEN, IMDATALEN (32 only), RESET_PC.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   im_if              : instruction memory read channel (master)
//   o_dbg_state_valid  : fetched instruction waiting in ST_STEP
//   i_dbg_state_ready  : step acknowledge, sampled only in ST_STEP
//   o_dbg_state_data   : registered FSM state
//   o_dbg_instr_data   : last fetched instruction
//   i_dbg_imm_data     : immediate / target for the next PC
//   i_dbg_pc_incr_op   : next-PC select
//   o_dbg_pc_data      : current PC
// Build option CORE_DBG_STEP_EN: when defined, ST_STEP waits for
// i_dbg_state_ready and uses the supplied op/imm; otherwise the core
// free-runs at PC+4 and ignores the step inputs.
module core
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              IMADDRLEN = 32,
    parameter int              IMDATALEN = XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    if_axi4_lite.master          im_if,
    output logic                 o_dbg_state_valid,
    input  logic                 i_dbg_state_ready,
    output state_e               o_dbg_state_data,
    output logic [IMDATALEN-1:0] o_dbg_instr_data,
    input  logic [XLEN-1:0]      i_dbg_imm_data,
    input  logic [1:0]           i_dbg_pc_incr_op,
    output logic [XLEN-1:0]      o_dbg_pc_data
);

    state_e               state_q, state_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 valid_q, valid_d;
    logic [IMDATALEN-1:0] instr_q, instr_d;

    logic                 step_ready;
    logic [1:0]           step_op;
    logic [XLEN-1:0]      step_imm;
    logic                 pc_load;
    logic [XLEN-1:0]      pc;

`ifdef CORE_DBG_STEP_EN
    assign step_ready = i_dbg_state_ready;
    assign step_op    = i_dbg_pc_incr_op;
    assign step_imm   = i_dbg_imm_data;
`else
    assign step_ready = 1'b1;
    assign step_op    = PC_INC4;
    assign step_imm   = '0;

    logic unused_dbg;
    assign unused_dbg = ^{i_dbg_state_ready, i_dbg_pc_incr_op, i_dbg_imm_data};
`endif

    // Read errors are not reported anywhere; the instruction is taken as is.
    logic unused_rresp;
    assign unused_rresp = ^im_if.rresp;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (arvalid_q && im_if.arready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // rvalid outside ST_WAIT (e.g. a stale beat after reset) never lands here.
                if (rready_q && im_if.rvalid) begin
                    instr_d = im_if.rdata;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (step_ready) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are decoded from the next state so they come
        // straight out of flops and never depend combinationally on inputs.
        arvalid_d = (state_d == ST_FETCH);
        rready_d  = (state_d == ST_WAIT);
        valid_d   = (state_d == ST_STEP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
        end
    end

    pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (pc_load),
        .i_op   (step_op),
        .i_imm  (step_imm),
        .o_pc   (pc)
    );

    // PC only moves in ST_STEP, so araddr is stable for the whole fetch.
    logic [IMADDRLEN-1:0] araddr;
    if (IMADDRLEN <= XLEN) begin : g_addr_trunc
        assign araddr = pc[IMADDRLEN-1:0];
    end else begin : g_addr_ext
        assign araddr = {{(IMADDRLEN-XLEN){1'b0}}, pc};
    end

    assign im_if.arvalid     = arvalid_q;
    assign im_if.araddr      = araddr;
    assign im_if.rready      = rready_q;
    assign o_dbg_state_valid = valid_q;
    assign o_dbg_state_data  = state_q;
    assign o_dbg_instr_data  = instr_q;
    assign o_dbg_pc_data     = pc;

endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - self-checking bench for core: directed table, stall/hold, random traffic, reset abort, PC wrap
module tb_core;
    import core_pkg::*;

`ifdef CORE_DBG_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    if_axi4_lite #(.ADDR_W(32), .DATA_W(32)) im_if ();
    if_axi4_lite #(.ADDR_W(32), .DATA_W(32)) w_if ();

    logic        dbg_valid, dbg_ready;
    state_e      dbg_state;
    logic [31:0] dbg_instr, dbg_imm, dbg_pc;
    logic [1:0]  dbg_op;

    logic        w_valid, w_ready;
    state_e      w_state;
    logic [31:0] w_instr, w_imm, w_pc;
    logic [1:0]  w_op;

    core #(.XLEN(32), .IMADDRLEN(32), .IMDATALEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rstn(rstn), .im_if(im_if),
        .o_dbg_state_valid(dbg_valid), .i_dbg_state_ready(dbg_ready),
        .o_dbg_state_data(dbg_state), .o_dbg_instr_data(dbg_instr),
        .i_dbg_imm_data(dbg_imm), .i_dbg_pc_incr_op(dbg_op), .o_dbg_pc_data(dbg_pc)
    );

    core #(.XLEN(32), .IMADDRLEN(32), .IMDATALEN(32), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rstn(rstn), .im_if(w_if),
        .o_dbg_state_valid(w_valid), .i_dbg_state_ready(w_ready),
        .o_dbg_state_data(w_state), .o_dbg_instr_data(w_instr),
        .i_dbg_imm_data(w_imm), .i_dbg_pc_incr_op(w_op), .o_dbg_pc_data(w_pc)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference next-PC rule, straight from the op table.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] op,
                                             input logic [31:0] imm);
        logic [31:0] t;
        case (op)
            2'b00:   t = pc + 32'd4;
            2'b01:   t = pc + imm;
            2'b10:   t = imm;
            default: t = pc;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    // Knobs set by the main sequence, consumed by the bus/host process.
    bit          rand_mode = 0, host_ready = 1, check_rate = 0, inject_rvalid = 0;
    logic [1:0]  host_op = 2'b00;
    logic [31:0] host_imm = 32'h0, host_rdata = 32'h13;
    int          ar_stall_next = 0, r_delay_next = 0;

    // Observed/model state.
    int          cyc = 0, ar_count = 0, step_count = 0;
    int          last_ar_cyc = -1, last_stall_len = 0, stall_seen = 0;
    logic [31:0] model_pc = RESET_PC, exp_instr = 32'h0, last_ar_addr = 32'h0;
    logic [31:0] pend_data = 32'h0, prev_stall_addr = 32'h0;
    bit          have_instr = 0, pend = 0, fetch_started = 0, prev_stalled = 0, prev_hold = 0;
    int          stall_left = 0, rdelay_left = 0;
    logic        eff_ready;
    logic [1:0]  eff_op;
    logic [31:0] eff_imm;

    // Memory slave, step host and scoreboard, all evaluated at the falling edge.
    initial begin : bus_host
        im_if.arready = 1'b0; im_if.rvalid = 1'b0; im_if.rdata = 32'h0; im_if.rresp = 2'b00;
        dbg_ready = 1'b0; dbg_op = 2'b00; dbg_imm = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                pend = 0; model_pc = RESET_PC; have_instr = 0; fetch_started = 0;
                prev_stalled = 0; prev_hold = 0; last_ar_cyc = -1; stall_seen = 0;
                im_if.arready = 1'b0; im_if.rvalid = inject_rvalid; im_if.rdata = 32'hDEAD_BEEF;
                continue;
            end

            // Read data channel.
            if (pend && rdelay_left == 0) begin
                im_if.rvalid = 1'b1; im_if.rdata = pend_data;
            end else begin
                if (pend) rdelay_left--;
                im_if.rvalid = inject_rvalid; im_if.rdata = 32'hDEAD_BEEF;
            end
            im_if.rresp = 2'($urandom);

            // Read address channel.
            if (im_if.arvalid) begin
                if (!fetch_started) begin
                    fetch_started = 1; stall_seen = 0;
                    stall_left = rand_mode ? int'($urandom_range(0, 3)) : ar_stall_next;
                    ar_stall_next = 0;
                end
                if (stall_left > 0) begin
                    im_if.arready = 1'b0; stall_left--;
                end else begin
                    im_if.arready = 1'b1;
                end
            end else begin
                im_if.arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            // Step host.
            if (rand_mode) begin
                dbg_ready = 1'($urandom_range(0, 1)); dbg_op = 2'($urandom); dbg_imm = $urandom;
            end else begin
                dbg_ready = host_ready; dbg_op = host_op; dbg_imm = host_imm;
            end
            eff_ready = STEP_EN ? dbg_ready : 1'b1;
            eff_op    = STEP_EN ? dbg_op : 2'b00;
            eff_imm   = STEP_EN ? dbg_imm : 32'h0;

            // Scoreboard.
            if (im_if.arvalid && !im_if.arready) begin
                if (prev_stalled) begin
                    chk("araddr_stable", im_if.araddr, prev_stall_addr);
                    chk("fetch_hold_state", 32'(dbg_state), 32'(ST_FETCH));
                end
                prev_stalled = 1; prev_stall_addr = im_if.araddr; stall_seen++;
            end else begin
                prev_stalled = 0;
            end

            if (im_if.rvalid && im_if.rready) begin
                chk("r_outstanding", 32'(pend), 32'd1);
                exp_instr = pend_data; have_instr = 1; pend = 0;
            end

            if (im_if.arvalid && im_if.arready) begin
                chk("araddr", im_if.araddr, model_pc);
                if (check_rate && last_ar_cyc >= 0) chk("loop_cycles", 32'(cyc - last_ar_cyc), 32'd3);
                last_ar_cyc = cyc; last_stall_len = stall_seen; last_ar_addr = im_if.araddr;
                ar_count++; fetch_started = 0; pend = 1;
                rdelay_left = rand_mode ? int'($urandom_range(0, 3)) : r_delay_next;
                pend_data   = rand_mode ? $urandom : host_rdata;
            end

            if (dbg_valid) begin
                if (have_instr) chk("instr", dbg_instr, exp_instr);
                chk("pc", dbg_pc, model_pc);
                if (eff_ready) begin
                    model_pc = ref_next(model_pc, eff_op, eff_imm);
                    step_count++; prev_hold = 0;
                end else begin
                    prev_hold = 1;
                end
            end else if (prev_hold) begin
                chk("valid_held", 32'(dbg_valid), 32'd1);
                prev_hold = 0;
            end
        end
    end

    // Zero-wait memory for the wrap instance; records its first fetch addresses.
    logic [31:0] wq[$];
    initial begin : wrap_mem
        w_if.arready = 1'b0; w_if.rvalid = 1'b0; w_if.rdata = 32'h0; w_if.rresp = 2'b00;
        w_ready = 1'b1; w_op = 2'b00; w_imm = 32'h0;
        forever begin
            @(negedge clk);
            w_if.arready = 1'b1;
            w_if.rvalid  = w_if.rready;
            w_if.rdata   = 32'h13;
            if (rstn && w_if.arvalid && wq.size() < 4) wq.push_back(w_if.araddr);
        end
    end

    task automatic wait_steps(input int target, input int budget, input string name);
        int g = 0;
        while (step_count < target && g < budget) begin @(negedge clk); #1; g++; end
        if (step_count < target) begin
            checks++; failures++;
            $display("FAIL %s timeout steps=%0d required=%0d", name, step_count, target);
        end
    endtask

    task automatic wait_ar(input int target, input int budget, input string name);
        int g = 0;
        while (ar_count < target && g < budget) begin @(negedge clk); #1; g++; end
        if (ar_count < target) begin
            checks++; failures++;
            $display("FAIL %s timeout fetches=%0d required=%0d", name, ar_count, target);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        chk({tag, "_pc"}, dbg_pc, RESET_PC);
        chk({tag, "_instr"}, dbg_instr, 32'h0);
        chk({tag, "_arvalid"}, 32'(im_if.arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(im_if.rready), 32'd0);
        chk({tag, "_valid"}, 32'(dbg_valid), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] imm;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[10];
    initial begin : main
        int s0, a0, g;
        // With stepping enabled each row drives the op; free-running always goes +4.
        tbl[0] = '{2'b10, 32'h0000_0103, STEP_EN ? 32'h0000_0100 : 32'd4};
        tbl[1] = '{2'b01, 32'hFFFF_FFF0, STEP_EN ? 32'h0000_00F0 : 32'd8};
        tbl[2] = '{2'b10, 32'h0000_0203, STEP_EN ? 32'h0000_0200 : 32'd12};
        tbl[3] = '{2'b00, 32'h1234_5678, STEP_EN ? 32'h0000_0204 : 32'd16};
        tbl[4] = '{2'b11, 32'h0000_0000, STEP_EN ? 32'h0000_0204 : 32'd20};
        tbl[5] = '{2'b10, 32'h0000_0043, STEP_EN ? 32'h0000_0040 : 32'd24};
        tbl[6] = '{2'b11, 32'h0000_0000, STEP_EN ? 32'h0000_0040 : 32'd28};
        tbl[7] = '{2'b10, 32'hFFFF_FFFE, STEP_EN ? 32'hFFFF_FFFC : 32'd32};
        tbl[8] = '{2'b00, 32'h0000_0000, STEP_EN ? 32'h0000_0000 : 32'd36};
        tbl[9] = '{2'b01, 32'h0000_0010, STEP_EN ? 32'h0000_0010 : 32'd40};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");

        rstn = 1'b1;
        @(negedge clk); #1;
        chk("idle_to_fetch", 32'(dbg_state), 32'(ST_FETCH));
        chk("first_arvalid", 32'(im_if.arvalid), 32'd1);

        // Directed next-PC table with zero-wait memory.
        check_rate = 1;
        for (int i = 0; i < 10; i++) begin
            host_op = tbl[i].op; host_imm = tbl[i].imm;
            s0 = step_count;
            wait_steps(s0 + 1, 50, "tbl_step");
            a0 = ar_count;
            wait_ar(a0 + 1, 50, "tbl_fetch");
            chk($sformatf("tbl%0d_addr", i), last_ar_addr, tbl[i].exp_addr);
        end
        check_rate = 0;
        host_op = 2'b00; host_imm = 32'h0;

        // Address stall for five cycles.
        ar_stall_next = 5;
        a0 = ar_count;
        wait_ar(a0 + 1, 60, "stall_fetch");
        chk("stall_len", 32'(last_stall_len), 32'd5);

        // Step acknowledge withheld for ten cycles.
        host_ready = 0;
        g = 0;
        while (!dbg_valid && g < 50) begin @(negedge clk); #1; g++; end
        chk("hold_reached_step", 32'(dbg_valid), 32'd1);
        s0 = step_count;
        repeat (10) @(negedge clk);
        #1;
        if (STEP_EN) begin
            chk("hold_steps_frozen", 32'(step_count), 32'(s0));
            chk("hold_valid", 32'(dbg_valid), 32'd1);
        end
        host_ready = 1;

        // Random traffic.
        rand_mode = 1;
        s0 = step_count;
        wait_steps(s0 + 300, 20000, "random_steps");
        rand_mode = 0;

        // Reset while waiting for read data, then a stale rvalid after release.
        r_delay_next = 6;
        a0 = ar_count;
        wait_ar(a0 + 1, 100, "pre_abort_fetch");
        @(negedge clk); #1;
        chk("abort_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("abort");
        r_delay_next = 0;
        ar_stall_next = 4;
        inject_rvalid = 1;
        a0 = ar_count;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("stale_rvalid_instr%0d", k), dbg_instr, 32'h0);
        end
        inject_rvalid = 0;
        wait_ar(a0 + 1, 50, "post_abort_fetch");
        chk("post_abort_araddr", last_ar_addr, RESET_PC);
        chk("post_abort_instr", dbg_instr, 32'h0);
        s0 = step_count;
        wait_steps(s0 + 2, 50, "post_abort_steps");

        // PC wrap on the second instance.
        chk("wrap_fetches", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            chk("wrap_addr0", wq[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", wq[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", wq[2], 32'h0000_0000);
            chk("wrap_addr3", wq[3], 32'h0000_0004);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
